// File: rtl/bcd_rtc_clock_pkg.sv
// Shared BCD constants and helpers for the hh:mm:ss clock.
// Hour conversion helpers keep 12h and 24h forms interchangeable.
package rtc_pkg;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  typedef struct packed {
    logic       pm;
    logic [7:0] hh;
  } hour_t;

  function automatic logic [6:0] bcd2bin(
    input logic [7:0] v
  );
    return {3'b0, v[7:4]} * 7'd10
         + {3'b0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(
    input logic [6:0] b
  );
    logic [6:0] t;
    logic [6:0] u;
    t = b / 7'd10;
    u = b % 7'd10;
    return 8'({t, 4'h0} | {4'h0, u});
  endfunction

  function automatic logic [7:0] bcd_inc_wrap(
    input logic [7:0] val,
    input logic [7:0] max
  );
    if (val == max)
      return BCD_00;
    if (val[3:0] == 4'd9)
      return {val[7:4] + 4'd1, 4'h0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_valid(
    input logic [7:0] val,
    input logic [7:0] max
  );
    return (val[7:4] <= 4'd9)
        && (val[3:0] <= 4'd9)
        && (val <= max);
  endfunction

  function automatic logic [7:0] hr12_to_24(
    input logic [7:0] hh,
    input logic       pm
  );
    if (hh == BCD_12)
      return pm ? BCD_12 : BCD_00;
    if (pm)
      return bin2bcd(bcd2bin(hh) + 7'd12);
    return hh;
  endfunction

  function automatic hour_t hr24_to_12(
    input logic [7:0] hh
  );
    hour_t      r;
    logic [6:0] b;
    logic [6:0] h;
    b    = bcd2bin(hh);
    r.pm = (b >= 7'd12);
    h    = r.pm ? b - 7'd12 : b;
    if (h == 7'd0)
      h = 7'd12;
    r.hh = bin2bcd(h);
    return r;
  endfunction

endpackage

// File: rtl/bcd_rtc_clock_if.sv
// Control/time bundle between the host side and the RTC.
// master drives controls, slave returns the registered time.
interface bcd_rtc_clock_if;

  logic       ena;
  logic       mode24;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_pm;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_pm;
  logic       alarm_clr;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       sec_tick;
  logic       alarm_flag;
  logic       load_err;

  modport master (
    output ena, mode24, load,
    output load_hh, load_mm, load_ss,
    output load_pm,
    output alarm_hh, alarm_mm,
    output alarm_pm, alarm_clr,
    input  hh, mm, ss, pm,
    input  sec_tick, alarm_flag,
    input  load_err
  );

  modport slave (
    input  ena, mode24, load,
    input  load_hh, load_mm, load_ss,
    input  load_pm,
    input  alarm_hh, alarm_mm,
    input  alarm_pm, alarm_clr,
    output hh, mm, ss, pm,
    output sec_tick, alarm_flag,
    output load_err
  );

endinterface

// File: rtl/bcd_mod60_cnt.sv
// 8-bit BCD counter 00..59 with load and wrap carry.
// nxt exposes the value the counter takes at the next edge.
module bcd_mod60_cnt
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic [7:0] nxt,
  output logic       carry_out
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    carry_out = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d     = bcd_inc_wrap(cnt_q, BCD_59);
      carry_out = (cnt_q == BCD_59);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= BCD_00;
    else
      cnt_q <= cnt_d;
  end

  assign q   = cnt_q;
  assign nxt = cnt_d;

endmodule

// File: rtl/bcd_rtc_clock.sv
// BCD hh:mm:ss clock with ena prescaler, 12h/24h mode,
// validated time load and minute-resolution alarm.
module bcd_rtc_clock
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter bit ALARM_EN = 1'b1
) (
  input logic            clk,
  input logic            reset,
  bcd_rtc_clock_if.slave bus
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hh_q, hh_d, hh_t;
  logic          pm_q, pm_d, pm_t;
  logic          mode_q, mode_d;
  logic          act_q, act_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          alm_q, alm_d;

  logic          tick;
  logic          hh_ok;
  logic          load_ok;
  logic          adv;
  logic          ss_carry;
  logic          mm_carry;
  logic          alarm_hit;
  logic [7:0]    ss_q, ss_nxt;
  logic [7:0]    mm_q, mm_nxt;
  hour_t         h12;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (bus.ena) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    if (load_ok)
      pre_d = '0;
  end

  // hour range depends on the format the registers hold now
  always_comb begin
    hh_ok = act_q
      ? bcd_valid(bus.load_hh, BCD_23)
      : bcd_valid(bus.load_hh, BCD_12)
        && (bus.load_hh != BCD_00);
    load_ok = bus.load && hh_ok
      && bcd_valid(bus.load_mm, BCD_59)
      && bcd_valid(bus.load_ss, BCD_59);
    adv = tick && !load_ok;
  end

  bcd_mod60_cnt u_ss (
    .clk       (clk),
    .reset     (reset),
    .inc       (adv),
    .load      (load_ok),
    .load_val  (bus.load_ss),
    .q         (ss_q),
    .nxt       (ss_nxt),
    .carry_out (ss_carry)
  );

  bcd_mod60_cnt u_mm (
    .clk       (clk),
    .reset     (reset),
    .inc       (ss_carry),
    .load      (load_ok),
    .load_val  (bus.load_mm),
    .q         (mm_q),
    .nxt       (mm_nxt),
    .carry_out (mm_carry)
  );

  always_comb begin
    hh_t = hh_q;
    pm_t = pm_q;
    unique case (1'b1)
      load_ok: begin
        hh_t = bus.load_hh;
        pm_t = act_q ? (bus.load_hh >= BCD_12)
                     : bus.load_pm;
      end
      mm_carry && act_q: begin
        hh_t = bcd_inc_wrap(hh_q, BCD_23);
        pm_t = (hh_t >= BCD_12);
      end
      mm_carry && !act_q: begin
        hh_t = (hh_q == BCD_12)
          ? BCD_01
          : bcd_inc_wrap(hh_q, BCD_12);
        pm_t = pm_q ^ (hh_q == BCD_11);
      end
      default: ;
    endcase
  end

  // conversion acts on the already advanced hour
  always_comb begin
    mode_d = bus.mode24;
    act_d  = act_q;
    hh_d   = hh_t;
    pm_d   = pm_t;
    h12    = hr24_to_12(hh_t);
    if (mode_q != act_q) begin
      act_d = mode_q;
      if (mode_q) begin
        hh_d = hr12_to_24(hh_t, pm_t);
      end else begin
        hh_d = h12.hh;
        pm_d = h12.pm;
      end
    end
  end

  always_comb begin
    alarm_hit = ALARM_EN && adv
      && (ss_nxt == BCD_00)
      && (mm_nxt == bus.alarm_mm)
      && (hh_t == bus.alarm_hh)
      && (act_q || (pm_t == bus.alarm_pm));
    alm_d = alm_q;
    if (alarm_hit)
      alm_d = 1'b1;
    else if (bus.alarm_clr)
      alm_d = 1'b0;
    tick_d = adv;
    err_d  = bus.load && !load_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      hh_q   <= bus.mode24 ? BCD_00 : BCD_12;
      pm_q   <= 1'b0;
      mode_q <= bus.mode24;
      act_q  <= bus.mode24;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      alm_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      hh_q   <= hh_d;
      pm_q   <= pm_d;
      mode_q <= mode_d;
      act_q  <= act_d;
      tick_q <= tick_d;
      err_q  <= err_d;
      alm_q  <= alm_d;
    end
  end

  assign bus.hh         = hh_q;
  assign bus.mm         = mm_q;
  assign bus.ss         = ss_q;
  assign bus.pm         = pm_q;
  assign bus.sec_tick   = tick_q;
  assign bus.alarm_flag = alm_q;
  assign bus.load_err   = err_q;

endmodule
